// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the block-RAM stream reader.
// Defaults match the team's 1K x 16 simple dual-port RAM.
package bram_stream_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int FIFO_DEPTH = 3;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Three-entry register FIFO that holds captured RAM words ({last, data})
// ahead of the output stream. The caller guarantees it never pushes when full.
module bram_rd_fifo
  import bram_stream_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [W-1:0]     mem_d [FIFO_DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    // Simultaneous push and pop leave the occupancy unchanged.
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps a wrapping address region of a 1-cycle-latency block RAM and
// presents the words as a valid/ready stream, with credit-based read issue.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  state_e            state_q, state_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              ram_last_q, ram_last_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic [CNT_W:0]    occ_next;

  assign m_valid          = (fifo_count != '0);
  assign {m_last, m_data} = fifo_head;
  assign pop              = m_valid & m_ready;

  bram_rd_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({infl_last_q, ram_dout}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    // Occupancy next cycle counting the read issued this cycle as in flight.
    // Issuing only while this stays below depth keeps the FIFO from overflowing.
    occ_next = {1'b0, fifo_count}
             + {{CNT_W{1'b0}}, inflight_q}
             - {{CNT_W{1'b0}}, pop}
             + {{CNT_W{1'b0}}, ram_en_q};

    state_d     = state_q;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_en_q ? ram_addr_q + ADDR_W'(1) : ram_addr_q;
    remaining_d = remaining_q;
    ram_last_d  = 1'b0;
    inflight_d  = ram_en_q;
    infl_last_d = ram_en_q & ram_last_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            ram_en_d    = 1'b1;
            ram_addr_d  = start_addr;
            remaining_d = length - (ADDR_W + 1)'(1);
            ram_last_d  = (length == (ADDR_W + 1)'(1));
          end
        end
      end
      RUN: begin
        if (remaining_q != '0 && occ_next < (CNT_W + 1)'(FIFO_DEPTH)) begin
          ram_en_d    = 1'b1;
          remaining_d = remaining_q - (ADDR_W + 1)'(1);
          ram_last_d  = (remaining_q == (ADDR_W + 1)'(1));
        end
        if (ram_en_q && ram_last_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      remaining_q <= '0;
      ram_last_q  <= 1'b0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      remaining_q <= remaining_d;
      ram_last_q  <= ram_last_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ram_en   = ram_en_q;
  assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a command table plus hand-written
// reset and overlap sequences, against a preloaded behavioural RAM.
module tb_bram_stream_reader;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy, done, ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  logic [DW-1:0] mem [1 << AW];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // mode 0: m_ready=1; mode 1: m_ready 1,0,0,1 repeating; mode 2: m_ready=1
  // plus a stray start (addr 100, length 5) while busy.
  task automatic run_cmd(input logic [AW-1:0] a, input logic [AW:0] len, input int mode,
                         output int first_data, output int last_data, output int done_cyc);
    int nw, issued, dones, first_cyc, addr_err, credit_err, stable_err, last_err, busy_err;
    bit prev_stall, any_busy, any_valid, any_en;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic [AW-1:0] exp_addr;
    first_data = -1; last_data = -1; done_cyc = -1; first_cyc = -1;
    nw = 0; issued = 0; dones = 0; addr_err = 0; credit_err = 0;
    stable_err = 0; last_err = 0; busy_err = 0;
    prev_stall = 0; any_busy = 0; any_valid = 0; any_en = 0;
    prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = a; length = len;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (mode == 2 && cyc == 2) begin
        start = 1'b1; start_addr = 10'd100; length = 11'd5;
      end else begin
        start = 1'b0;
      end
      m_ready = (mode == 1) ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
      #1;
      if (busy) any_busy = 1;
      if (m_valid) any_valid = 1;
      if (ram_en) begin
        any_en = 1;
        exp_addr = a + AW'(issued);
        if (ram_addr !== exp_addr) addr_err++;
        if (issued - nw >= 3) credit_err++;
        issued++;
      end
      if (m_valid && prev_stall && (m_data !== prev_data || m_last !== prev_last)) stable_err++;
      if (m_valid && m_ready) begin
        chk("stream_data", int'(m_data), ((int'(a) + nw) % (1 << AW)) + 'h100);
        if (m_last !== (nw == int'(len) - 1)) last_err++;
        if (nw == 0) begin first_data = int'(m_data); first_cyc = cyc; end
        last_data = int'(m_data);
        nw++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy) busy_err++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen_before_timeout", int'(done_cyc >= 0), 1);
    chk("done_pulse_count", dones, 1);
    chk("word_count", nw, int'(len));
    chk("read_count", issued, int'(len));
    chk("ram_addr_errors", addr_err, 0);
    chk("credit_errors", credit_err, 0);
    chk("stall_stability_errors", stable_err, 0);
    chk("m_last_errors", last_err, 0);
    chk("busy_during_done", busy_err, 0);
    if (len == 0) begin
      chk("len0_busy_seen", int'(any_busy), 0);
      chk("len0_valid_seen", int'(any_valid), 0);
      chk("len0_ram_en_seen", int'(any_en), 0);
    end else if (mode != 1) begin
      chk("first_valid_latency", first_cyc, 3);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    int            mode;
    int            exp_first;
    int            exp_last;
    int            exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_done"},     int'(done),     0);
    chk({tag, "_ram_en"},   int'(ram_en),   0);
    chk({tag, "_m_valid"},  int'(m_valid),  0);
    chk({tag, "_m_last"},   int'(m_last),   0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_m_data"},   int'(m_data),   0);
  endtask

  initial begin
    int fd, ld, dc, got;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 'h100);

    vecs[0] = '{addr: 10'd5,    len: 11'd4,    mode: 0, exp_first: 'h105, exp_last: 'h108, exp_done: 7};
    vecs[1] = '{addr: 10'd1022, len: 11'd4,    mode: 0, exp_first: 'h4FE, exp_last: 'h101, exp_done: 7};
    vecs[2] = '{addr: 10'd0,    len: 11'd0,    mode: 0, exp_first: -1,    exp_last: -1,    exp_done: 1};
    vecs[3] = '{addr: 10'd100,  len: 11'd8,    mode: 1, exp_first: 'h164, exp_last: 'h16B, exp_done: -1};
    vecs[4] = '{addr: 10'd1023, len: 11'd1,    mode: 0, exp_first: 'h4FF, exp_last: 'h4FF, exp_done: 4};
    vecs[5] = '{addr: 10'd7,    len: 11'd3,    mode: 2, exp_first: 'h107, exp_last: 'h109, exp_done: 6};
    vecs[6] = '{addr: 10'd512,  len: 11'd1024, mode: 0, exp_first: 'h300, exp_last: 'h2FF, exp_done: 1027};

    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b0;
    #3;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_cmd(vecs[v].addr, vecs[v].len, vecs[v].mode, fd, ld, dc);
      chk($sformatf("vec%0d_first_word", v), fd, vecs[v].exp_first);
      chk($sformatf("vec%0d_last_word", v), ld, vecs[v].exp_last);
      if (vecs[v].exp_done >= 0) chk($sformatf("vec%0d_done_cycle", v), dc, vecs[v].exp_done);
    end

    // Asynchronous reset in the middle of a 6-word command.
    @(negedge clk);
    start = 1'b1; start_addr = 10'd10; length = 11'd6; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (m_valid && m_ready) got++;
      if (got < 2) @(negedge clk);
    end
    chk("midcmd_two_words_delivered", got, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_outputs_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    run_cmd(10'd0, 11'd2, 0, fd, ld, dc);
    chk("post_reset_first_word", fd, 'h100);
    chk("post_reset_last_word", ld, 'h101);
    chk("post_reset_done_cycle", dc, 5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
